// File: rtl/countdown_timer.sv
// Loadable down-counter with run/hold control, optional auto-reload
// and a one-cycle terminal-count pulse.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Stop,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] NIL = '0;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        if (Load) begin
            q_d = D;
            r_d = D;
            if (state_q == RUN && D == NIL) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start && q_q != NIL) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state_d = HOLD;
                    end else if (q_q > ONE) begin
                        q_d = q_q - ONE;
                    end else if (q_q == ONE) begin
                        done_d = 1'b1;
                        if (AutoReload) begin
                            q_d = r_q;
                            if (r_q <= ONE) begin
                                state_d = IDLE;
                            end
                        end else begin
                            q_d     = NIL;
                            state_d = IDLE;
                        end
                    end else begin
                        // Unreachable with Q == 0; never decrement past zero.
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (Start && !Stop) begin
                        state_d = (q_q != NIL) ? RUN : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            q_q     <= NIL;
            r_q     <= NIL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign Busy = (state_q == RUN);
    assign Done = done_q;
    assign Zero = (q_q == NIL);

endmodule
